// File: rtl/alu_pkg.sv
// Shared ALU definitions: selector codes, issue-controller state encoding and opcode legality.
package alu_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_MUL = 8'h03;
    localparam logic [7:0] OP_DIV = 8'h04;
    localparam logic [7:0] OP_SHL = 8'h0D;
    localparam logic [7:0] OP_SHR = 8'h0E;
    localparam logic [7:0] OP_CMP = 8'h0F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV,
            OP_SHL, OP_SHR, OP_CMP: is_legal_op = 1'b1;
            default:                is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one op at a time to the combinational ALU, holds inputs SETTLE_CYC cycles, captures
// X/Flags into a response held until rsp_ready (legal: SETTLE_CYC+2 edges, illegal: 1 edge).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int TAG_W      = 4,
    parameter int DIVZ_BIT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_op,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [7:0]       alu_sel,
    input  logic [7:0]       alu_x,
    input  logic [7:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_x,
    output logic [7:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [7:0]       flags_q,
    output logic             busy
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic [7:0]         r_alu_a;
    logic [7:0]         r_alu_b;
    logic [7:0]         r_alu_sel;
    logic [7:0]         r_rsp_x;
    logic [7:0]         r_rsp_flags;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic               r_rsp_err;
    logic [7:0]         r_flags_q;
    logic               w_xfer;
    logic               w_legal;

    assign w_xfer  = req_valid && (r_state == IDLE);
    assign w_legal = is_legal_op(req_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_xfer) w_next = w_legal ? DRIVE : RESP;
            DRIVE:   if (r_cnt == 4'd0) w_next = CAPTURE;
            CAPTURE: w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ALU inputs only change on acceptance and on response completion, never mid-settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_alu_a     <= 8'd0;
            r_alu_b     <= 8'd0;
            r_alu_sel   <= 8'd0;
            r_rsp_x     <= 8'd0;
            r_rsp_flags <= 8'd0;
            r_rsp_tag   <= '0;
            r_rsp_err   <= 1'b0;
            r_flags_q   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_rsp_tag <= req_tag;
                        if (w_legal) begin
                            r_alu_a   <= req_a;
                            r_alu_b   <= req_b;
                            r_alu_sel <= req_op;
                            r_cnt     <= SETTLE_INIT;
                        end else begin
                            r_rsp_x     <= 8'd0;
                            r_rsp_flags <= 8'd0;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                CAPTURE: begin
                    r_rsp_x     <= alu_x;
                    r_rsp_flags <= alu_flags;
                    r_flags_q   <= alu_flags;
                    r_rsp_err   <= alu_flags[DIVZ_BIT] && (r_alu_sel == OP_DIV);
                end
                RESP: begin
                    if (rsp_ready) r_alu_sel <= 8'd0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign rsp_x     = r_rsp_x;
    assign rsp_flags = r_rsp_flags;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_err   = r_rsp_err;
    assign flags_q   = r_flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Two controllers (SETTLE_CYC=1 and 3) share one request/response stream, each driving its own ALU model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [7:0] req_op, req_a, req_b;
    logic [3:0] req_tag;
    logic       rsp_ready;

    logic       req_ready_s1, rsp_valid_s1, rsp_err_s1, busy_s1;
    logic [7:0] alu_a_s1, alu_b_s1, alu_sel_s1, alu_x_s1, alu_flags_s1;
    logic [7:0] rsp_x_s1, rsp_flags_s1, flags_q_s1;
    logic [3:0] rsp_tag_s1;

    logic       req_ready_s3, rsp_valid_s3, rsp_err_s3, busy_s3;
    logic [7:0] alu_a_s3, alu_b_s3, alu_sel_s3, alu_x_s3, alu_flags_s3;
    logic [7:0] rsp_x_s3, rsp_flags_s3, flags_q_s3;
    logic [3:0] rsp_tag_s3;

    int checks   = 0;
    int failures = 0;

    int         lat1, lat3;
    logic [7:0] x1, x3, fl1, fl3, sel1, sel3;
    logic       err1, err3;
    logic [3:0] tag1, tag3;
    logic       seen;

    always #5 clk = ~clk;

    // Behavioural ALU: bit0 div-by-zero, bit1 zero (cmp: equal), bit2 carry/borrow (cmp: A<B).
    function automatic logic [15:0] alu_fn(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  w;
        logic [15:0] p;
        logic [7:0]  x, f;
        x = 8'd0; f = 8'd0; w = 9'd0; p = 16'd0;
        case (sel)
            OP_ADD: begin w = {1'b0, a} + {1'b0, b}; x = w[7:0]; f[2] = w[8]; end
            OP_SUB: begin w = {1'b0, a} - {1'b0, b}; x = w[7:0]; f[2] = w[8]; end
            OP_MUL: begin p = a * b; x = p[7:0]; f[2] = |p[15:8]; end
            OP_DIV: begin
                if (b == 8'd0) begin x = 8'hFF; f[0] = 1'b1; end
                else x = a / b;
            end
            OP_SHL: x = a << b[2:0];
            OP_SHR: x = a >> b[2:0];
            OP_CMP: begin f[1] = (a == b); f[2] = (a < b); end
            default: x = 8'd0;
        endcase
        if (sel != OP_CMP) f[1] = (x == 8'd0);
        return {f, x};
    endfunction

    assign {alu_flags_s1, alu_x_s1} = alu_fn(alu_sel_s1, alu_a_s1, alu_b_s1);
    assign {alu_flags_s3, alu_x_s3} = alu_fn(alu_sel_s3, alu_a_s3, alu_b_s3);

    alu_issue_ctrl #(.SETTLE_CYC(1), .TAG_W(4), .DIVZ_BIT(0)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_s1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(alu_a_s1), .alu_b(alu_b_s1), .alu_sel(alu_sel_s1),
        .alu_x(alu_x_s1), .alu_flags(alu_flags_s1),
        .rsp_valid(rsp_valid_s1), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x_s1), .rsp_flags(rsp_flags_s1), .rsp_tag(rsp_tag_s1), .rsp_err(rsp_err_s1),
        .flags_q(flags_q_s1), .busy(busy_s1)
    );

    alu_issue_ctrl #(.SETTLE_CYC(3), .TAG_W(4), .DIVZ_BIT(0)) u_s3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_s3),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(alu_a_s3), .alu_b(alu_b_s3), .alu_sel(alu_sel_s3),
        .alu_x(alu_x_s3), .alu_flags(alu_flags_s3),
        .rsp_valid(rsp_valid_s3), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x_s3), .rsp_flags(rsp_flags_s3), .rsp_tag(rsp_tag_s3), .rsp_err(rsp_err_s3),
        .flags_q(flags_q_s3), .busy(busy_s3)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Transfer at edge T; k counts edges after T at which rsp_valid is first seen (rsp_ready=1).
    task automatic do_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        lat1 = -1; lat3 = -1;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (rsp_valid_s1 && lat1 < 0) begin
                lat1 = k; x1 = rsp_x_s1; fl1 = rsp_flags_s1; err1 = rsp_err_s1;
                tag1 = rsp_tag_s1; sel1 = alu_sel_s1;
            end
            if (rsp_valid_s3 && lat3 < 0) begin
                lat3 = k; x3 = rsp_x_s3; fl3 = rsp_flags_s3; err3 = rsp_err_s3;
                tag3 = rsp_tag_s3; sel3 = alu_sel_s3;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 8'd0; req_a = 8'd0; req_b = 8'd0;
        req_tag = 4'd0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs_s1", {alu_a_s1, alu_b_s1, alu_sel_s1, rsp_x_s1, rsp_flags_s1, rsp_tag_s1,
                              flags_q_s1, rsp_valid_s1, rsp_err_s1, busy_s1}, 64'd0);
        chk("reset_outs_s3", {alu_a_s3, alu_b_s3, alu_sel_s3, rsp_x_s3, rsp_flags_s3, rsp_tag_s3,
                              flags_q_s3, rsp_valid_s3, rsp_err_s3, busy_s3}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("reset_req_ready", {req_ready_s1, req_ready_s3}, 2'b11);

        do_op(OP_ADD, 8'd3, 8'd2, 4'h1);
        chk("add_lat_s1", lat1, 2);
        chk("add_lat_s3", lat3, 4);
        chk("add_x", {x1, x3}, {8'd5, 8'd5});
        chk("add_err", {err1, err3}, 2'b00);
        chk("add_tag", {tag1, tag3}, {4'h1, 4'h1});
        chk("add_idle_after", {busy_s1, busy_s3, alu_sel_s1, alu_sel_s3}, 18'd0);

        do_op(OP_MUL, 8'd10, 8'd15, 4'hA);
        chk("mul_x", {x1, x3}, {8'h96, 8'h96});
        chk("mul_tag", {tag1, tag3}, {4'hA, 4'hA});
        chk("mul_lat", {lat1[7:0], lat3[7:0]}, {8'd2, 8'd4});

        do_op(OP_DIV, 8'd8, 8'd0, 4'h3);
        chk("div0_err", {err1, err3}, 2'b11);
        chk("div0_flags", {fl1, fl3}, {8'h01, 8'h01});
        chk("div0_flags_q_divz", {flags_q_s1[0], flags_q_s3[0]}, 2'b11);

        do_op(OP_DIV, 8'd8, 8'd2, 4'h4);
        chk("div_x", {x1, x3}, {8'd4, 8'd4});
        chk("div_err", {err1, err3}, 2'b00);
        chk("div_flags_q", {flags_q_s1, flags_q_s3}, 16'h0000);

        do_op(OP_CMP, 8'd5, 8'd5, 4'h2);
        chk("cmp_flags", {fl1, fl3}, {8'h02, 8'h02});
        chk("cmp_flags_q", {flags_q_s1, flags_q_s3}, {8'h02, 8'h02});

        do_op(8'h07, 8'd9, 8'd9, 4'h5);
        chk("ill_lat", {lat1[7:0], lat3[7:0]}, {8'd0, 8'd0});
        chk("ill_err", {err1, err3}, 2'b11);
        chk("ill_x_flags", {x1, x3, fl1, fl3}, 32'd0);
        chk("ill_tag", {tag1, tag3}, {4'h5, 4'h5});
        chk("ill_sel", {sel1, sel3}, 16'd0);
        chk("ill_flags_q", {flags_q_s1, flags_q_s3}, {8'h02, 8'h02});

        // Stalled response with a second request waiting behind it.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_op = OP_SHL; req_a = 8'd1; req_b = 8'd2; req_tag = 4'h6; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = OP_ADD; req_a = 8'd3; req_b = 8'd2; req_tag = 4'h7;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            seen = rsp_valid_s3;
        end
        chk("shl_rsp_seen", seen, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("shl_hold_s3", {rsp_valid_s3, rsp_x_s3, rsp_tag_s3}, {1'b1, 8'd4, 4'h6});
            chk("shl_hold_s1", {rsp_valid_s1, rsp_x_s1, rsp_tag_s1}, {1'b1, 8'd4, 4'h6});
            chk("shl_req_ready", {req_ready_s1, req_ready_s3}, 2'b00);
            @(posedge clk); #1;
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_not_accepted", {busy_s1, busy_s3, rsp_valid_s1, rsp_valid_s3}, 4'b0000);
        chk("hs_sel_cleared", {alu_sel_s1, alu_sel_s3}, 16'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("second_accepted", {busy_s1, busy_s3, alu_sel_s3}, {2'b11, OP_ADD});
        lat3 = -1;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid_s3 && lat3 < 0) begin lat3 = k; x3 = rsp_x_s3; tag3 = rsp_tag_s3; end
        end
        chk("second_lat_s3", lat3, 4);
        chk("second_rsp", {x3, tag3}, {8'd5, 4'h7});

        // Reset during DRIVE.
        @(negedge clk);
        req_op = OP_SUB; req_a = 8'd4; req_b = 8'd2; req_tag = 4'h8; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sub_in_drive", {busy_s3, alu_sel_s3, alu_a_s3}, {1'b1, OP_SUB, 8'd4});
        rst_n = 1'b0;
        #1;
        chk("abort_outs_s1", {alu_a_s1, alu_b_s1, alu_sel_s1, rsp_x_s1, rsp_flags_s1, rsp_tag_s1,
                              flags_q_s1, rsp_valid_s1, rsp_err_s1, busy_s1}, 64'd0);
        chk("abort_outs_s3", {alu_a_s3, alu_b_s3, alu_sel_s3, rsp_x_s3, rsp_flags_s3, rsp_tag_s3,
                              flags_q_s3, rsp_valid_s3, rsp_err_s3, busy_s3}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("abort_req_ready", {req_ready_s1, req_ready_s3}, 2'b11);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid_s1 | rsp_valid_s3 | busy_s1 | busy_s3;
        end
        chk("abort_no_rsp", seen, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
